// File: rtl/sklansky_pkg.sv
// Shared types and helpers for the Sklansky prefix adder.
// Latency: none (types/functions only).
// Backpressure: not applicable.
package sklansky_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels; 0 for a single-bit adder.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

    // Black cell: hi is the more significant group, lo the adjacent lower one.
    function automatic gp_t prefix_op(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/sklansky_prefix_tree.sv
// Sklansky prefix tree: bitwise g/p in, group generates G[i:0] out.
// Latency: combinational.
// Backpressure: none.
module sklansky_prefix_tree
    import sklansky_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] grp_g
);

    localparam int L = clog2(WIDTH);

    // Level 0 holds the inputs; level l+1 is the result of combining at bit l.
    for (genvar l = 0; l <= L; l++) begin : g_lvl
        gp_t node [WIDTH];
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (l == 0) begin : g_in
                assign node[i] = '{g: g[i], p: p[i]};
            end else if (((i >> (l - 1)) & 1) == 1) begin : g_black
                localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
                assign node[i] = prefix_op(g_lvl[l-1].node[i], g_lvl[l-1].node[J]);
            end else begin : g_pass
                assign node[i] = g_lvl[l-1].node[i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_out
        assign grp_g[i] = g_lvl[L].node[i].g;
    end

endmodule

// File: rtl/sklansky_adder.sv
// Registered parallel-prefix adder: {Cout,Sum} = A + B + Cin.
// Latency: 1 cycle, one result per cycle.
// Backpressure: none; consumers qualify Sum/Cout with out_valid.
module sklansky_adder
    import sklansky_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g_cin;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;

    assign g = A & B;
    assign p = A ^ B;

    // Fold carry-in into bit 0 so the tree sees it as an ordinary generate.
    always_comb begin
        g_cin    = g;
        g_cin[0] = g[0] | (p[0] & Cin);
    end

    sklansky_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .g     (g_cin),
        .p     (p),
        .grp_g (grp_g)
    );

    assign carry   = {grp_g, Cin};
    assign sum_nxt = p ^ carry[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            Sum       <= sum_nxt;
            Cout      <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_sklansky_adder.sv
// Directed and swept checks of sklansky_adder at WIDTH 1, 4, 5, 8, 16.
module tb_sklansky_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  a4, b4;
    logic        cin;
    logic        ov4, co4;
    logic [3:0]  s4;

    logic [0:0]  a1, b1, s1;
    logic [4:0]  a5, b5, s5;
    logic [7:0]  a8, b8, s8;
    logic [15:0] a16, b16, s16;
    logic        ov1, ov5, ov8, ov16, co1, co5, co8, co16;

    int checks = 0;
    int fails  = 0;

    sklansky_adder #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a4), .B(b4), .Cin(cin),
        .out_valid(ov4), .Sum(s4), .Cout(co4));
    sklansky_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a1), .B(b1), .Cin(cin),
        .out_valid(ov1), .Sum(s1), .Cout(co1));
    sklansky_adder #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a5), .B(b5), .Cin(cin),
        .out_valid(ov5), .Sum(s5), .Cout(co5));
    sklansky_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a8), .B(b8), .Cin(cin),
        .out_valid(ov8), .Sum(s8), .Cout(co8));
    sklansky_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a16), .B(b16), .Cin(cin),
        .out_valid(ov16), .Sum(s16), .Cout(co16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vectors with hand-computed results.
    logic [3:0] va  [6] = '{4'b1101, 4'b0110, 4'b1111, 4'b0101, 4'b1010, 4'b1111};
    logic [3:0] vb  [6] = '{4'b1011, 4'b1001, 4'b0001, 4'b0011, 4'b0101, 4'b1111};
    logic       vc  [6] = '{1'b0,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
    logic [3:0] vs  [6] = '{4'b1000, 4'b1111, 4'b0000, 4'b1000, 4'b1111, 4'b1111};
    logic       vco [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};

    initial begin
        logic [4:0]  e4;
        logic [1:0]  e1;
        logic [5:0]  e5;
        logic [8:0]  e8;
        logic [16:0] e16;

        rst_n = 1'b0; in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; cin = 1'b1;
        a1 = '0; b1 = '0; a5 = '0; b5 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) tick();
        check("reset_sum", 32'(s4), 32'h0);
        check("reset_cout", 32'(co4), 32'h0);
        check("reset_valid", 32'(ov4), 32'h0);

        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a4 = va[k]; b4 = vb[k]; cin = vc[k]; in_valid = 1'b1;
            tick();
            check($sformatf("dir%0d_sum", k), 32'(s4), 32'(vs[k]));
            check($sformatf("dir%0d_cout", k), 32'(co4), 32'(vco[k]));
            check($sformatf("dir%0d_valid", k), 32'(ov4), 32'h1);
        end

        a4 = 4'b1111; b4 = 4'b0000; cin = 1'b1;
        tick();
        check("ripple_sum", 32'(s4), 32'h0);
        check("ripple_cout", 32'(co4), 32'h1);

        // Back-to-back stream with an in_valid bubble after the third vector.
        for (int k = 0; k < 7; k++) begin
            int idx;
            idx = (k < 3) ? k : ((k == 3) ? 0 : k - 1);
            a4 = va[idx]; b4 = vb[idx]; cin = vc[idx]; in_valid = (k != 3);
            tick();
            check($sformatf("b2b%0d_sum", k), 32'(s4), 32'(vs[idx]));
            check($sformatf("b2b%0d_cout", k), 32'(co4), 32'(vco[idx]));
            check($sformatf("b2b%0d_valid", k), 32'(ov4), (k != 3) ? 32'h1 : 32'h0);
        end
        in_valid = 1'b1;

        for (int n = 0; n < 512; n++) begin
            a4 = n[3:0]; b4 = n[7:4]; cin = n[8];
            e4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin};
            tick();
            check($sformatf("exh_%0h_%0h_%0h", a4, b4, cin), 32'({co4, s4}), 32'(e4));
        end

        for (int n = 0; n < 200; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a5 = 5'($urandom); b5 = 5'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            a16 = (n == 0) ? 16'hFFFF : 16'($urandom);
            b16 = (n == 0) ? 16'hFFFF : 16'($urandom);
            cin = (n == 0) ? 1'b1 : 1'($urandom);
            e1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin};
            e5  = {1'b0, a5} + {1'b0, b5} + {5'b0, cin};
            e8  = {1'b0, a8} + {1'b0, b8} + {8'b0, cin};
            e16 = {1'b0, a16} + {1'b0, b16} + {16'b0, cin};
            tick();
            check($sformatf("w1_%0d", n), 32'({co1, s1}), 32'(e1));
            check($sformatf("w5_%0d", n), 32'({co5, s5}), 32'(e5));
            check($sformatf("w8_%0d", n), 32'({co8, s8}), 32'(e8));
            check($sformatf("w16_%0d", n), 32'({co16, s16}), 32'(e16));
            check($sformatf("wvalid_%0d", n), 32'({ov1, ov5, ov8, ov16}), 32'hF);
        end

        // Asynchronous reset between edges while a result is held.
        a4 = 4'b0111; b4 = 4'b0111; cin = 1'b1;
        tick();
        check("pre_rst_sum", 32'({ov4, co4, s4}), 32'b1_0_1111);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", 32'(s4), 32'h0);
        check("async_rst_cout", 32'(co4), 32'h0);
        check("async_rst_valid", 32'(ov4), 32'h0);
        check("async_rst_w16", 32'({ov16, co16, s16}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("post_rst_idle", 32'(ov4), 32'h0);
        a4 = 4'b1001; b4 = 4'b0100; cin = 1'b1; in_valid = 1'b1;
        tick();
        check("post_rst_result", 32'({ov4, co4, s4}), 32'b1_0_1110);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
